// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM controller command port between the display
// reader (port 0), the camera frame writer (port 1) and the HDR tone-map
// writer (port 2). Each port owns a one-deep pending slot. Port 0 has fixed
// top priority; ports 1 and 2 alternate round-robin.
// Optional build macro: ARB_DROP_CNT_EN adds saturating per-writer counters
// of request pulses dropped on a full slot.
module ram_arbiter #(
  parameter int AW     = 25,
  parameter int DW     = 256,
  parameter int SETTLE = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_address,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  input  logic          cam_wr_req,
  input  logic [AW-1:0] cam_wr_address,
  input  logic [DW-1:0] cam_wr_data,
  input  logic          hdr_wr_req,
  input  logic [AW-1:0] hdr_wr_address,
  input  logic [DW-1:0] hdr_wr_data,
  output logic          cam_busy,
  output logic          hdr_busy,
`ifdef ARB_DROP_CNT_EN
  output logic [15:0]   cam_drop_cnt,
  output logic [15:0]   hdr_drop_cnt,
`endif
  output logic          ram_wr_req,
  output logic          ram_rd_req,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_wr_data,
  input  logic          ram_busy_in,
  input  logic          ram_rd_valid,
  input  logic [DW-1:0] ram_rd_data
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_SETTLE, ST_WAIT} state_t;
  typedef enum logic [1:0] {P_RD = 2'd0, P_CAM = 2'd1, P_HDR = 2'd2} port_t;

  state_t        state;
  port_t         win;
  logic          rr_hdr;     // 0: camera favoured, 1: HDR favoured
  logic [CW-1:0] cnt;

  logic [2:0]    pending;
  logic [2:0]    req;
  logic [2:0]    clear;
  logic [2:0]    load;

  logic [AW-1:0] rd_addr_q;
  logic [AW-1:0] cam_addr_q;
  logic [AW-1:0] hdr_addr_q;
  logic [DW-1:0] cam_data_q;
  logic [DW-1:0] hdr_data_q;

  assign req   = {hdr_wr_req, cam_wr_req, rd_req};
  // The winner's slot empties on the ISSUE edge; a pulse on that same edge
  // refills it, so load is allowed when the slot is empty or being cleared.
  assign clear = (state == ST_ISSUE) ? (3'b001 << win) : 3'b000;
  assign load  = req & (~pending | clear);

  assign cam_busy = pending[1];
  assign hdr_busy = pending[2];

  // Pending flags: set on an accepted pulse, cleared when the slot issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 3'b000;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // block sees the pre-edge values of pending/state/win.
      pending <= (pending & ~clear) | load;
    end
  end

  // Slot payload capture, qualified by the pending flags.
  always_ff @(posedge clk) begin
    // NOTE: payload registers carry no reset; they are only ever read
    // while their pending bit is set, and pending is reset.
    if (load[0]) rd_addr_q <= rd_address;
    if (load[1]) begin
      cam_addr_q <= cam_wr_address;
      cam_data_q <= cam_wr_data;
    end
    if (load[2]) begin
      hdr_addr_q <= hdr_wr_address;
      hdr_data_q <= hdr_wr_data;
    end
  end

  // Command FSM: arbitration, issue, settle count and completion tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      win         <= P_RD;
      rr_hdr      <= 1'b0;
      cnt         <= '0;
      ram_wr_req  <= 1'b0;
      ram_rd_req  <= 1'b0;
      ram_address <= '0;
      ram_wr_data <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
    end else begin
      ram_wr_req <= 1'b0;
      ram_rd_req <= 1'b0;
      rd_valid   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if ((|pending) && !ram_busy_in) begin
            if (pending[0]) begin
              win <= P_RD;
            end else if (pending[1] && (!rr_hdr || !pending[2])) begin
              win    <= P_CAM;
              rr_hdr <= 1'b1;
            end else begin
              win    <= P_HDR;
              rr_hdr <= 1'b0;
            end
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          case (win)
            P_RD: begin
              ram_rd_req  <= 1'b1;
              ram_address <= rd_addr_q;
            end
            P_CAM: begin
              ram_wr_req  <= 1'b1;
              ram_address <= cam_addr_q;
              ram_wr_data <= cam_data_q;
            end
            default: begin
              ram_wr_req  <= 1'b1;
              ram_address <= hdr_addr_q;
              ram_wr_data <= hdr_data_q;
            end
          endcase
          cnt   <= '0;
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt == CW'(SETTLE - 1)) state <= ST_WAIT;
          else                        cnt   <= cnt + 1'b1;
        end
        ST_WAIT: begin
          if (win == P_RD) begin
            if (ram_rd_valid) begin
              rd_valid <= 1'b1;
              rd_data  <= ram_rd_data;
              state    <= ST_IDLE;
            end
          end else if (!ram_busy_in) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ARB_DROP_CNT_EN
  logic cam_drop;
  logic hdr_drop;
  assign cam_drop = cam_wr_req & pending[1] & ~clear[1];
  assign hdr_drop = hdr_wr_req & pending[2] & ~clear[2];

  // Saturating counters of pulses lost on a full slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cam_drop_cnt <= 16'h0000;
      hdr_drop_cnt <= 16'h0000;
    end else begin
      if (cam_drop && cam_drop_cnt != 16'hFFFF) cam_drop_cnt <= cam_drop_cnt + 16'h0001;
      if (hdr_drop && hdr_drop_cnt != 16'hFFFF) hdr_drop_cnt <= hdr_drop_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed stimulus for ram_arbiter with a transaction-level
// model (slots, priority choice, command age) compared on every cycle, plus
// hand-computed literal expectations.
module tb_ram_arbiter;

  localparam int AW     = 25;
  localparam int DW     = 256;
  localparam int SETTLE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_address = '0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          cam_wr_req = 1'b0;
  logic [AW-1:0] cam_wr_address = '0;
  logic [DW-1:0] cam_wr_data = '0;
  logic          hdr_wr_req = 1'b0;
  logic [AW-1:0] hdr_wr_address = '0;
  logic [DW-1:0] hdr_wr_data = '0;
  logic          cam_busy;
  logic          hdr_busy;
  logic          ram_wr_req;
  logic          ram_rd_req;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_wr_data;
  logic          ram_busy_in = 1'b0;
  logic          ram_rd_valid = 1'b0;
  logic [DW-1:0] ram_rd_data = '0;
`ifdef ARB_DROP_CNT_EN
  logic [15:0]   cam_drop_cnt;
  logic [15:0]   hdr_drop_cnt;
`endif

  int tests = 0;
  int fails = 0;

  ram_arbiter #(.AW(AW), .DW(DW), .SETTLE(SETTLE)) dut (
    .clk            (clk),
    .rst            (rst),
    .rd_req         (rd_req),
    .rd_address     (rd_address),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .cam_wr_req     (cam_wr_req),
    .cam_wr_address (cam_wr_address),
    .cam_wr_data    (cam_wr_data),
    .hdr_wr_req     (hdr_wr_req),
    .hdr_wr_address (hdr_wr_address),
    .hdr_wr_data    (hdr_wr_data),
    .cam_busy       (cam_busy),
    .hdr_busy       (hdr_busy),
`ifdef ARB_DROP_CNT_EN
    .cam_drop_cnt   (cam_drop_cnt),
    .hdr_drop_cnt   (hdr_drop_cnt),
`endif
    .ram_wr_req     (ram_wr_req),
    .ram_rd_req     (ram_rd_req),
    .ram_address    (ram_address),
    .ram_wr_data    (ram_wr_data),
    .ram_busy_in    (ram_busy_in),
    .ram_rd_valid   (ram_rd_valid),
    .ram_rd_data    (ram_rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit            m_pend [3];
  logic [AW-1:0] m_addr [3];
  logic [DW-1:0] m_data [3];
  int            m_fav;      // favoured writer port (1 or 2)
  int            m_launch;   // port whose command goes out on the next edge, -1 none
  int            m_age;      // edges since the outstanding command's strobe, -1 none
  bit            m_is_read;
  bit            m_free;
  int            m_drop [3];
  logic          exp_wr, exp_rd, exp_valid;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata, exp_rdata;

  task automatic model_reset();
    for (int p = 0; p < 3; p++) begin
      m_pend[p] = 0;
      m_drop[p] = 0;
    end
    m_fav = 1; m_launch = -1; m_age = -1; m_is_read = 0; m_free = 1;
    exp_wr = 0; exp_rd = 0; exp_valid = 0;
    exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
  endtask

  task automatic model_step();
    bit            req [3];
    logic [AW-1:0] a [3];
    logic [DW-1:0] d [3];
    req[0] = rd_req;     a[0] = rd_address;     d[0] = '0;
    req[1] = cam_wr_req; a[1] = cam_wr_address; d[1] = cam_wr_data;
    req[2] = hdr_wr_req; a[2] = hdr_wr_address; d[2] = hdr_wr_data;
    exp_wr = 0; exp_rd = 0; exp_valid = 0;
    if (m_launch >= 0) begin
      if (m_launch == 0) exp_rd = 1;
      else begin
        exp_wr    = 1;
        exp_wdata = m_data[m_launch];
      end
      exp_addr         = m_addr[m_launch];
      m_pend[m_launch] = 0;
      m_is_read        = (m_launch == 0);
      m_age            = 0;
      m_launch         = -1;
    end else if (m_age >= 0) begin
      m_age++;
      if (m_age > SETTLE) begin
        if (m_is_read && ram_rd_valid) begin
          exp_valid = 1;
          exp_rdata = ram_rd_data;
          m_age = -1; m_free = 1;
        end else if (!m_is_read && !ram_busy_in) begin
          m_age = -1; m_free = 1;
        end
      end
    end else if (m_free && (m_pend[0] || m_pend[1] || m_pend[2]) && !ram_busy_in) begin
      if (m_pend[0])                  m_launch = 0;
      else if (m_pend[1] && m_pend[2]) m_launch = m_fav;
      else                            m_launch = m_pend[1] ? 1 : 2;
      if (m_launch != 0) m_fav = 3 - m_launch;
      m_free = 0;
    end
    for (int p = 0; p < 3; p++) begin
      if (req[p]) begin
        if (!m_pend[p]) begin
          m_pend[p] = 1;
          m_addr[p] = a[p];
          m_data[p] = d[p];
        end else if (m_drop[p] < 65535) begin
          m_drop[p]++;
        end
      end
    end
  endtask

  task automatic compare_cycle();
    check("ram_wr_req",  ram_wr_req,  exp_wr);
    check("ram_rd_req",  ram_rd_req,  exp_rd);
    check("ram_address", ram_address, exp_addr);
    check("ram_wr_data", ram_wr_data, exp_wdata);
    check("rd_valid",    rd_valid,    exp_valid);
    check("rd_data",     rd_data,     exp_rdata);
    check("cam_busy",    cam_busy,    m_pend[1]);
    check("hdr_busy",    hdr_busy,    m_pend[2]);
`ifdef ARB_DROP_CNT_EN
    check("cam_drop_cnt", cam_drop_cnt, m_drop[1][15:0]);
    check("hdr_drop_cnt", hdr_drop_cnt, m_drop[2][15:0]);
`endif
  endtask

  // Model update and output comparison, once per cycle, 1 ns after the edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else     model_step();
      #1;
      compare_cycle();
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    tick();
    rst = 1'b1;
    rd_req = 0; cam_wr_req = 0; hdr_wr_req = 0;
    ram_busy_in = 0; ram_rd_valid = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_rd(input logic [AW-1:0] a);
    rd_address = a; rd_req = 1'b1; tick(); rd_req = 1'b0;
  endtask

  task automatic pulse_cam(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cam_wr_address = a; cam_wr_data = d; cam_wr_req = 1'b1; tick(); cam_wr_req = 1'b0;
  endtask

  task automatic pulse_hdr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    hdr_wr_address = a; hdr_wr_data = d; hdr_wr_req = 1'b1; tick(); hdr_wr_req = 1'b0;
  endtask

  task automatic wait_strobe(input string name, input int max);
    int n = 0;
    while (!(ram_wr_req || ram_rd_req) && n < max) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, ram_wr_req || ram_rd_req, 1'b1);
  endtask

  logic [DW-1:0] pat_a5, pat_d, pat_x, pat_c1, pat_h1, pat_h2;
  bit            order [$];
  int            strobes;

  initial begin
    pat_a5 = {8{32'hA5A5_A5A5}};
    pat_d  = {8{32'hDEAD_BEEF}};
    pat_x  = {8{32'h0BAD_0BAD}};
    pat_c1 = {8{32'h1111_2222}};
    pat_h1 = {8{32'h3333_4444}};
    pat_h2 = {8{32'h5555_6666}};

    // Reset state
    tick();
    check("rst_ram_wr_req", ram_wr_req, 1'b0);
    check("rst_ram_address", ram_address, '0);
    check("rst_cam_busy", cam_busy, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    rst = 1'b0;
    tick();

    // Single write: strobe two edges after the capture edge
    pulse_hdr(25'hE1000, pat_a5);
    check("single_busy_capt", hdr_busy, 1'b1);
    tick();
    check("single_no_strobe_yet", ram_wr_req, 1'b0);
    check("single_busy_hold", hdr_busy, 1'b1);
    tick();
    check("single_wr_req", ram_wr_req, 1'b1);
    check("single_addr", ram_address, 25'hE1000);
    check("single_data", ram_wr_data, pat_a5);
    check("single_busy_clr", hdr_busy, 1'b0);
    repeat (8) tick();

    // Drop on a full slot
    reset_dut();
    pulse_hdr(25'h0AAAA, pat_h1);
    pulse_hdr(25'h0BBBB, pat_h2);
    wait_strobe("drop", 10);
    check("drop_addr", ram_address, 25'h0AAAA);
    check("drop_data", ram_wr_data, pat_h1);
    strobes = 0;
    repeat (15) begin
      tick();
      if (ram_wr_req || ram_rd_req) strobes++;
    end
    check("drop_no_second", strobes, 0);
`ifdef ARB_DROP_CNT_EN
    check("drop_cnt_lit", hdr_drop_cnt, 16'd1);
`endif

    // Read priority over a simultaneous camera write
    reset_dut();
    rd_address = 25'h0001234; rd_req = 1'b1;
    cam_wr_address = 25'h0000200; cam_wr_data = pat_c1; cam_wr_req = 1'b1;
    tick();
    rd_req = 1'b0; cam_wr_req = 1'b0;
    wait_strobe("prio", 10);
    check("prio_rd_first", ram_rd_req, 1'b1);
    check("prio_no_wr", ram_wr_req, 1'b0);
    check("prio_rd_addr", ram_address, 25'h0001234);
    ram_rd_valid = 1'b1; ram_rd_data = pat_x;   // too early: still settling
    tick();
    ram_rd_valid = 1'b0;
    tick(); tick();
    ram_rd_valid = 1'b1; ram_rd_data = pat_d;
    tick();
    ram_rd_valid = 1'b0;
    check("prio_rd_valid", rd_valid, 1'b1);
    check("prio_rd_data", rd_data, pat_d);
    tick();
    check("prio_rd_valid_pulse", rd_valid, 1'b0);
    wait_strobe("prio_cam", 10);
    check("prio_cam_wr", ram_wr_req, 1'b1);
    check("prio_cam_addr", ram_address, 25'h0000200);
    check("prio_cam_data", ram_wr_data, pat_c1);
    repeat (8) tick();

    // Busy stall
    reset_dut();
    ram_busy_in = 1'b1;
    pulse_cam(25'h0013579, pat_c1);
    strobes = 0;
    repeat (20) begin
      tick();
      if (ram_wr_req || ram_rd_req) strobes++;
    end
    check("stall_no_strobe", strobes, 0);
    ram_busy_in = 1'b0;
    tick();
    check("stall_release_wait", ram_wr_req, 1'b0);
    tick();
    check("stall_issue", ram_wr_req, 1'b1);
    check("stall_addr", ram_address, 25'h0013579);
    repeat (8) tick();

    // Round-robin with both writers continuously requesting
    reset_dut();
    cam_wr_req = 1'b1; hdr_wr_req = 1'b1;
    cam_wr_address = 25'h0000000; hdr_wr_address = 25'h1000000;
    cam_wr_data = '0; hdr_wr_data = '1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (ram_wr_req) order.push_back(ram_address[AW-1]);
      cam_wr_address = {1'b0, 24'(cyc)};
      hdr_wr_address = {1'b1, 24'(cyc)};
      cam_wr_data = {8{32'(cyc)}};
      hdr_wr_data = ~{8{32'(cyc)}};
    end
    cam_wr_req = 1'b0; hdr_wr_req = 1'b0;
    check("rr_count", order.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i < order.size()) check($sformatf("rr_order_%0d", i), order[i], (i % 2) == 1);
    end

    // Reset during a read WAIT
    reset_dut();
    pulse_rd(25'h1ABCDEF);
    wait_strobe("mid", 10);
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    check("mid_rst_addr", ram_address, '0);
    check("mid_rst_rd_req", ram_rd_req, 1'b0);
    check("mid_rst_rd_valid", rd_valid, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();
    ram_rd_valid = 1'b1; ram_rd_data = pat_d;
    tick();
    ram_rd_valid = 1'b0;
    strobes = 0;
    repeat (6) begin
      tick();
      if (rd_valid || ram_wr_req || ram_rd_req) strobes++;
    end
    check("mid_late_valid_ignored", strobes, 0);
    check("mid_rd_data_zero", rd_data, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
